// File: rtl/dtc_share_ctrl_pkg.sv
// dtc_share_ctrl shared types: FSM state enum, error counter width,
// and the thermometer decode helper used by therm_decode.
package dtc_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        EVAL,
        RESP
    } state_t;

    localparam int ERR_CNT_W = 16;

    // Count of contiguous ones starting at bit 0 of the low ow bits.
    function automatic int therm_class(
        input logic [31:0] code,
        input int          ow
    );
        int   c;
        logic run;
        c   = 0;
        run = 1'b1;
        for (int i = 0; i < 32; i++) begin
            if (run && (i < ow) && code[i]) begin
                c = c + 1;
            end else begin
                run = 1'b0;
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/dtc_share_ctrl_if.sv
// Request/response handshake bundle for dtc_share_ctrl.
// master: requesters + response consumer; slave: the controller.
interface dtc_share_ctrl_if #(
    parameter int NREQ = 4,
    parameter int W    = 9,
    parameter int OW   = 9
);
    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(OW + 1);

    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IW-1:0]     rsp_id;
    logic [OW-1:0]     rsp_code;
    logic [CW-1:0]     rsp_class;
    logic              rsp_err;

    modport master (
        output req_valid, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_id,
        input  rsp_code, rsp_class, rsp_err
    );

    modport slave (
        input  req_valid, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_id,
        output rsp_code, rsp_class, rsp_err
    );

endinterface

// File: rtl/dtc_share_ctrl_therm_decode.sv
// therm_decode: combinational thermometer decoder.
// in: code[OW]; out: cls (ones from LSB), err (a one above the first zero).
module therm_decode
    import dtc_ctrl_pkg::*;
#(
    parameter  int OW = 9,
    localparam int CW = $clog2(OW + 1)
) (
    input  logic [OW-1:0] code,
    output logic [CW-1:0] cls,
    output logic          err
);

    assign cls = CW'(therm_class(32'(code), OW));

    // Bit cls is the first zero, so any set bit left after the shift
    // lies above it and breaks the 0..01..1 form.
    assign err = (int'(cls) < OW) && (|(code >> cls));

endmodule

// File: rtl/dtc_share_ctrl.sv
// dtc_share_ctrl: round-robin time-sharing of one decision tree among
// NREQ requesters. Ports: clk, rst, bus (slave), tree_inp/tree_outp, err_count.
module dtc_share_ctrl
    import dtc_ctrl_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int W      = 9,
    parameter int OW     = 9,
    parameter int SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    dtc_share_ctrl_if.slave      bus,
    output logic [W-1:0]         tree_inp,
    input  logic [OW-1:0]        tree_outp,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int IW  = $clog2(NREQ);
    localparam int CW  = $clog2(OW + 1);
    localparam int SCW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    state_t               state_q;
    state_t               state_d;
    logic [IW-1:0]        ptr_q;
    logic [IW-1:0]        id_q;
    logic [SCW-1:0]       cnt_q;
    logic [W-1:0]         inp_q;
    logic [OW-1:0]        code_q;
    logic [ERR_CNT_W-1:0] err_q;

    logic                 gnt_found;
    logic [IW-1:0]        gnt;
    logic                 accept;
    logic                 capture;
    logic                 rsp_hs;
    logic [CW-1:0]        dec_cls;
    logic                 dec_err;

    // First valid requester at or after ptr, wrapping.
    always_comb begin
        int idx;
        gnt_found = 1'b0;
        gnt       = '0;
        idx       = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr_q) + k) % NREQ;
            if (!gnt_found && bus.req_valid[IW'(idx)]) begin
                gnt_found = 1'b1;
                gnt       = IW'(idx);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        capture = 1'b0;
        rsp_hs  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (gnt_found) begin
                    accept  = 1'b1;
                    state_d = EVAL;
                end
            end
            EVAL: begin
                if (cnt_q == '0) begin
                    capture = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_hs  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            cnt_q   <= '0;
            inp_q   <= '0;
            code_q  <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                inp_q <= bus.req_data[int'(gnt)*W +: W];
                id_q  <= gnt;
                ptr_q <= (int'(gnt) == NREQ - 1) ? '0 : gnt + 1'b1;
                cnt_q <= SCW'(SETTLE - 1);
            end else if (state_q == EVAL && cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
            end
            if (capture) begin
                code_q <= tree_outp;
            end
            if (rsp_hs && dec_err && err_q != '1) begin
                err_q <= err_q + 1'b1;
            end
        end
    end

    therm_decode #(.OW(OW)) u_dec (
        .code (code_q),
        .cls  (dec_cls),
        .err  (dec_err)
    );

    assign bus.req_ready = accept ? (NREQ'(1) << gnt) : '0;
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_id    = id_q;
    assign bus.rsp_code  = code_q;
    assign bus.rsp_class = dec_cls;
    assign bus.rsp_err   = dec_err;
    assign tree_inp      = inp_q;
    assign err_count     = err_q;

endmodule

// File: tb/tb_dtc_share_ctrl.sv
// Self-checking bench for dtc_share_ctrl: cycle model of the sharing rules
// plus directed scenarios with literal expectations.
module tb_dtc_share_ctrl;

    localparam int NREQ = 4;
    localparam int W    = 9;
    localparam int OW   = 9;
    localparam int S0   = 1;
    localparam int S1   = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int pass_n = 0;
    int tot_n  = 0;

    dtc_share_ctrl_if #(.NREQ(NREQ), .W(W), .OW(OW)) b0 ();
    dtc_share_ctrl_if #(.NREQ(NREQ), .W(W), .OW(OW)) b1 ();

    logic [W-1:0]  ti0, ti1;
    logic [OW-1:0] to0, to1;
    logic [15:0]   ec0, ec1;

    function automatic logic [OW-1:0] tree_fn(input logic [W-1:0] d);
        if (d == 9'h1A5) return 9'h01F;
        if (d == 9'h0AA) return 9'h017;
        return d;
    endfunction

    assign to0 = tree_fn(ti0);
    always @(posedge clk) to1 <= ti1;

    dtc_share_ctrl #(.NREQ(NREQ), .W(W), .OW(OW), .SETTLE(S0)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (b0),
        .tree_inp  (ti0),
        .tree_outp (to0),
        .err_count (ec0)
    );

    dtc_share_ctrl #(.NREQ(NREQ), .W(W), .OW(OW), .SETTLE(S1)) dut3 (
        .clk       (clk),
        .rst       (rst),
        .bus       (b1),
        .tree_inp  (ti1),
        .tree_outp (to1),
        .err_count (ec1)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tot_n++;
        if (act === exp) pass_n++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    task automatic tmo(input string nm);
        tot_n++;
        $display("FAIL %s: timed out waiting", nm);
    endtask

    function automatic int exp_class(input logic [OW-1:0] c);
        int k = 0;
        while (k < OW && c[k]) k++;
        return k;
    endfunction

    function automatic bit exp_err(input logic [OW-1:0] c);
        int k = exp_class(c);
        return (k < OW) && ((c >> k) != 0);
    endfunction

    // Model: one transaction in flight; response due SETTLE+1 cycles
    // after its accept; back to arbitration the cycle after handshake.
    bit           m_busy = 0;
    int           m_acc  = 0;
    int           m_ptr  = 0;
    int           m_err  = 0;
    int           m_id   = 0;
    logic [W-1:0] m_data = '0;
    logic [W-1:0] m_tree = '0;
    int           acc_cyc[$];
    int           acc_id[$];

    always @(negedge clk) begin
        int              g;
        bit              ev;
        logic [OW-1:0]   c;
        logic [NREQ-1:0] er;
        if (rst) begin
            m_busy = 0;
            m_ptr  = 0;
            m_tree = '0;
            m_err  = 0;
        end else begin
            g = -1;
            c = '0;
            if (!m_busy) begin
                for (int k = 0; k < NREQ; k++) begin
                    if (g < 0 && b0.req_valid[(m_ptr + k) % NREQ])
                        g = (m_ptr + k) % NREQ;
                end
            end
            er = '0;
            if (g >= 0) er[g] = 1'b1;
            ev = m_busy && (cyc >= m_acc + S0 + 1);
            chk("req_ready", 32'(b0.req_ready), 32'(er));
            chk("tree_inp", 32'(ti0), 32'(m_tree));
            chk("err_count", 32'(ec0), m_err);
            chk("rsp_valid", 32'(b0.rsp_valid), 32'(ev));
            if (ev) begin
                c = tree_fn(m_data);
                chk("rsp_id", 32'(b0.rsp_id), m_id);
                chk("rsp_code", 32'(b0.rsp_code), 32'(c));
                chk("rsp_class", 32'(b0.rsp_class), exp_class(c));
                chk("rsp_err", 32'(b0.rsp_err), 32'(exp_err(c)));
            end
            if (g >= 0) begin
                m_busy = 1;
                m_acc  = cyc;
                m_id   = g;
                m_data = b0.req_data[g*W +: W];
                m_tree = m_data;
                m_ptr  = (g + 1) % NREQ;
                acc_cyc.push_back(cyc);
                acc_id.push_back(g);
            end else if (ev && b0.rsp_ready) begin
                m_busy = 0;
                if (exp_err(c) && m_err < 65535) m_err++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [W-1:0] d);
        b0.req_valid[i]         = v;
        b0.req_data[i*W +: W]   = d;
    endtask

    task automatic wait_acc(input int n, input string nm);
        int k = 0;
        while (acc_cyc.size() < n && k < 60) begin
            step();
            k++;
        end
        if (acc_cyc.size() < n) tmo(nm);
    endtask

    task automatic wait_rsp(input string nm, output int rc);
        int k = 0;
        rc = -1;
        @(negedge clk);
        while (!b0.rsp_valid && k < 60) begin
            @(negedge clk);
            k++;
        end
        if (b0.rsp_valid) rc = cyc;
        else tmo(nm);
    endtask

    initial begin
        int rc;
        int n;
        int t;
        b0.req_valid = '0;
        b0.req_data  = '0;
        b0.rsp_ready = 1'b1;
        b1.req_valid = '0;
        b1.req_data  = '0;
        b1.rsp_ready = 1'b1;

        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_rsp_valid", 32'(b0.rsp_valid), 0);
        chk("rst_rsp_id", 32'(b0.rsp_id), 0);
        chk("rst_rsp_code", 32'(b0.rsp_code), 0);
        chk("rst_rsp_class", 32'(b0.rsp_class), 0);
        chk("rst_rsp_err", 32'(b0.rsp_err), 0);
        chk("rst_err_count", 32'(ec0), 0);
        chk("rst_tree_inp", 32'(ti0), 0);
        chk("rst_req_ready", 32'(b0.req_ready), 0);
        step();

        // all four requesting: rotation 0,1,2,3,0 every 3 cycles
        set_req(0, 1'b1, 9'h000);
        set_req(1, 1'b1, 9'h001);
        set_req(2, 1'b1, 9'h003);
        set_req(3, 1'b1, 9'h007);
        wait_acc(5, "rr_accepts");
        b0.req_valid = '0;
        if (acc_id.size() >= 5) begin
            chk("rr_g0", acc_id[0], 0);
            chk("rr_g1", acc_id[1], 1);
            chk("rr_g2", acc_id[2], 2);
            chk("rr_g3", acc_id[3], 3);
            chk("rr_g4", acc_id[4], 0);
            for (int i = 0; i < 4; i++)
                chk("rr_spacing", acc_cyc[i+1] - acc_cyc[i], 3);
        end
        repeat (4) step();

        // single request from requester 2
        set_req(2, 1'b1, 9'h1A5);
        wait_acc(6, "single_accept");
        set_req(2, 1'b0, 9'h1A5);
        wait_rsp("single_rsp", rc);
        if (acc_cyc.size() >= 6) chk("single_latency", rc - acc_cyc[5], 2);
        chk("single_id", 32'(b0.rsp_id), 2);
        chk("single_class", 32'(b0.rsp_class), 5);
        chk("single_err", 32'(b0.rsp_err), 0);
        chk("single_code", 32'(b0.rsp_code), 32'h01F);
        repeat (3) step();

        // back-pressure: ptr=3 so requester 0 wins, 1 waits
        b0.rsp_ready = 1'b0;
        set_req(1, 1'b1, 9'h0FF);
        set_req(0, 1'b1, 9'h000);
        wait_acc(7, "bp_accept");
        set_req(0, 1'b0, 9'h000);
        wait_rsp("bp_rsp", rc);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            if (b0.rsp_valid && b0.req_ready == '0 && ti0 == 9'h000 &&
                b0.rsp_id == 0)
                n++;
            @(negedge clk);
        end
        chk("bp_frozen_cycles", n, 10);
        step();
        b0.rsp_ready = 1'b1;
        wait_acc(8, "bp_release");
        set_req(1, 1'b0, 9'h0FF);
        if (acc_id.size() >= 8) chk("bp_next_grant", acc_id[7], 1);
        repeat (4) step();
        chk("bp_err_count", 32'(ec0), 0);

        // three malformed codes
        set_req(3, 1'b1, 9'h0AA);
        wait_acc(9, "err_accept");
        wait_rsp("err_rsp", rc);
        chk("err_class", 32'(b0.rsp_class), 3);
        chk("err_flag", 32'(b0.rsp_err), 1);
        chk("err_code", 32'(b0.rsp_code), 32'h017);
        wait_acc(11, "err_accept3");
        set_req(3, 1'b0, 9'h0AA);
        repeat (4) step();
        chk("err_count_3", 32'(ec0), 3);

        // saturation from a preloaded FFFE
        force dut.err_q = 16'hFFFE;
        m_err = 16'hFFFE;
        #1;
        release dut.err_q;
        set_req(3, 1'b1, 9'h0AA);
        wait_acc(14, "sat_accept");
        set_req(3, 1'b0, 9'h0AA);
        repeat (4) step();
        chk("err_count_sat", 32'(ec0), 32'hFFFF);

        // reset during EVAL drops the request
        set_req(2, 1'b1, 9'h033);
        wait_acc(15, "abort_accept");
        rst = 1'b1;
        set_req(2, 1'b0, 9'h033);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("abort_rsp_valid", 32'(b0.rsp_valid), 0);
        chk("abort_tree_inp", 32'(ti0), 0);
        chk("abort_err_count", 32'(ec0), 0);
        n = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (b0.rsp_valid) n++;
        end
        chk("abort_no_rsp", n, 0);
        step();
        set_req(1, 1'b1, 9'h07F);
        set_req(3, 1'b1, 9'h001);
        wait_acc(16, "abort_next");
        b0.req_valid = '0;
        if (acc_id.size() >= 16) chk("abort_ptr_reset", acc_id[15], 1);
        repeat (4) step();

        // SETTLE=3 instance with a one-cycle-late stub tree
        b1.req_valid[0]  = 1'b1;
        b1.req_data[8:0] = 9'h03F;
        t = -1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (b1.req_ready[0]) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) tmo("s3_accept");
        @(posedge clk);
        #1;
        b1.req_valid = '0;
        rc = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (b1.rsp_valid) begin
                rc = cyc;
                break;
            end
        end
        if (rc < 0) tmo("s3_rsp");
        chk("s3_latency", rc - t, 4);
        chk("s3_code", 32'(b1.rsp_code), 32'h03F);
        chk("s3_class", 32'(b1.rsp_class), 6);
        chk("s3_err", 32'(b1.rsp_err), 0);
        chk("s3_id", 32'(b1.rsp_id), 0);
        chk("s3_tree_inp", 32'(ti1), 32'h03F);
        repeat (3) step();

        $display("%0d/%0d checks passed", pass_n, tot_n);
        $finish;
    end

endmodule
